// File: rtl/alu_station_pkg.sv
// Shared ALU definitions: op-code encoding and the "no lock" tag value.
// Used by the reservation station and by any execute unit that decodes the same ops.
package alu_defs;

  // Tag value meaning "operand already holds its value".
  localparam int NO_LOCK = 0;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_PASS2 = 4'd10;

  // Station entry field order: valid, op, tag1, tag2, data1, data2, dest.
  localparam int ENTRY_FIELDS = 7;

endpackage

// File: rtl/alu_exec_unit.sv
// Purely combinational integer ALU: (op, a, b) -> result.
// Shifts use the low log2(DATA_W) bits of b; undefined ops yield 0.
module alu_exec_unit
  import alu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] w_shamt;
  assign w_shamt = i_b[SH_W-1:0];

  always_comb begin
    // NOTE: default assignment first so no path leaves o_result unassigned (no latch).
    o_result = '0;
    case (i_op)
      OP_W'(OP_ADD):   o_result = i_a + i_b;
      OP_W'(OP_SUB):   o_result = i_a - i_b;
      OP_W'(OP_AND):   o_result = i_a & i_b;
      OP_W'(OP_OR):    o_result = i_a | i_b;
      OP_W'(OP_XOR):   o_result = i_a ^ i_b;
      OP_W'(OP_SLL):   o_result = i_a << w_shamt;
      OP_W'(OP_SRL):   o_result = i_a >> w_shamt;
      OP_W'(OP_SRA):   o_result = $signed(i_a) >>> w_shamt;
      OP_W'(OP_SLT):   o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_W'(OP_SLTU):  o_result = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
      OP_W'(OP_PASS2): o_result = i_b;
      default:         o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_station.sv
// ALU reservation station: CDB wakeup, oldest-ready select via age matrix, one-deep result register.
// Optional ALU_STATION_PERF_EN adds saturating stall and dispatch counters.
module alu_station
  import alu_defs::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [TAG_W-1:0]  issue_tag1,
  input  logic [TAG_W-1:0]  issue_tag2,
  input  logic [DATA_W-1:0] issue_data1,
  input  logic [DATA_W-1:0] issue_data2,
  input  logic [TAG_W-1:0]  issue_dest,
  input  logic              cdb_in_valid,
  input  logic [TAG_W-1:0]  cdb_in_tag,
  input  logic [DATA_W-1:0] cdb_in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data
`ifdef ALU_STATION_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_disp_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] L_NO_LOCK = TAG_W'(NO_LOCK);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag1;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [TAG_W-1:0]  dest;
  } entry_t;

  entry_t            r_ent [DEPTH];
  logic [DEPTH-1:0]  r_age [DEPTH];  // r_age[i][j]: entry i is older than entry j
  logic              r_out_valid;
  logic [TAG_W-1:0]  r_out_tag;
  logic [DATA_W-1:0] r_out_data;

  logic [DEPTH-1:0]  w_valid, w_ready, w_oldest;
  logic              w_full, w_issue_fire, w_disp;
  logic [IDX_W-1:0]  w_free_idx, w_sel_idx;
  entry_t            w_new_ent;
  logic [DATA_W-1:0] w_result;

  always_comb begin
    w_valid = '0;
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_ready[i] = r_ent[i].valid && r_ent[i].tag1 == L_NO_LOCK && r_ent[i].tag2 == L_NO_LOCK;
    end
  end

  assign w_full       = &w_valid;
  assign issue_ready  = !w_full;
  assign w_issue_fire = issue_valid && !w_full && !flush;
  assign w_disp       = (!r_out_valid || out_ready) && (|w_ready) && !flush;

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!w_valid[i]) w_free_idx = IDX_W'(i);
  end

  // An entry wins when it is ready and older than every other ready entry.
  always_comb begin
    w_oldest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_oldest[i] = w_ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && w_ready[j] && !r_age[i][j]) w_oldest[i] = 1'b0;
    end
  end

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_oldest[i]) w_sel_idx = IDX_W'(i);
  end

  // Issue-time bypass: an operand broadcast in the same cycle is captured directly.
  always_comb begin
    w_new_ent.valid = 1'b1;
    w_new_ent.op    = issue_op;
    w_new_ent.dest  = issue_dest;
    w_new_ent.tag1  = issue_tag1;
    w_new_ent.data1 = issue_data1;
    w_new_ent.tag2  = issue_tag2;
    w_new_ent.data2 = issue_data2;
    if (cdb_in_valid && issue_tag1 != L_NO_LOCK && issue_tag1 == cdb_in_tag) begin
      w_new_ent.tag1  = L_NO_LOCK;
      w_new_ent.data1 = cdb_in_data;
    end
    if (cdb_in_valid && issue_tag2 != L_NO_LOCK && issue_tag2 == cdb_in_tag) begin
      w_new_ent.tag2  = L_NO_LOCK;
      w_new_ent.data2 = cdb_in_data;
    end
  end

  alu_exec_unit #(.DATA_W(DATA_W), .OP_W(OP_W)) u_exec (
    .i_op     (r_ent[w_sel_idx].op),
    .i_a      (r_ent[w_sel_idx].data1),
    .i_b      (r_ent[w_sel_idx].data2),
    .o_result (w_result)
  );

  always_ff @(posedge clk) begin
    // NOTE: only the valid bits are reset; payload fields are don't-care while invalid.
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_ent[i].valid && cdb_in_valid) begin
          if (r_ent[i].tag1 != L_NO_LOCK && r_ent[i].tag1 == cdb_in_tag) begin
            r_ent[i].tag1  <= L_NO_LOCK;
            r_ent[i].data1 <= cdb_in_data;
          end
          if (r_ent[i].tag2 != L_NO_LOCK && r_ent[i].tag2 == cdb_in_tag) begin
            r_ent[i].tag2  <= L_NO_LOCK;
            r_ent[i].data2 <= cdb_in_data;
          end
        end
      end
      if (w_disp)       r_ent[w_sel_idx].valid <= 1'b0;
      if (w_issue_fire) r_ent[w_free_idx]      <= w_new_ent;
    end
  end

  // A new entry becomes younger than everything; stale bits of free rows are never consulted.
  always_ff @(posedge clk) begin
    if (w_issue_fire) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_age[w_free_idx][j] <= 1'b0;
        if (j != int'(w_free_idx)) r_age[j][w_free_idx] <= 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_disp) begin
      r_out_valid <= 1'b1;
      r_out_tag   <= r_ent[w_sel_idx].dest;
      r_out_data  <= w_result;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_tag   = r_out_tag;
  assign out_data  = r_out_data;

`ifdef ALU_STATION_PERF_EN
  logic [31:0] r_perf_stall, r_perf_disp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_disp  <= '0;
    end else begin
      if (issue_valid && w_full && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_disp && r_perf_disp != '1)                 r_perf_disp  <= r_perf_disp + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_disp_cnt  = r_perf_disp;
`endif

endmodule

// File: doc/alu_station.md
Name: alu_station

Overview:
- Parametrised ALU reservation station with an integrated single-cycle execute stage. It sits between the Decoder and the CDB.
- Buffers up to DEPTH ALU ops and snoops the CDB to wake up locked operands. Among ready entries it selects the oldest, executes it, and holds the result in an output register until the CDB grants it.
- Compared with the previous ALU queue, it adds: generic depth and width, a full integer op set, oldest-first selection, an explicit CDB handshake, flush, and issue-time CDB bypass.

Parameters:
- DEPTH, 4, number of station entries (power of 2, ≥2).
- DATA_W, 32, operand/result width.
- TAG_W, 5, rename/lock tag width; tag 0 means "no lock".
- OP_W, 4, ALU op-code width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries and the pending result (mispredict)
- issue_valid  in  1  Decoder presents an op
- issue_ready  out  1  a free entry exists; transfer occurs when valid&ready
- issue_op  in  OP_W  ALU op
- issue_tag1 / issue_tag2  in  TAG_W  operand lock tags (0 = operand valid)
- issue_data1 / issue_data2  in  DATA_W  operand values (used when the tag is 0)
- issue_dest  in  TAG_W  destination lock tag
- cdb_in_valid  in  1  CDB broadcast valid
- cdb_in_tag  in  TAG_W  broadcast tag
- cdb_in_data  in  DATA_W  broadcast value
- out_valid  out  1  result pending for the CDB
- out_ready  in  1  CDB grant; result consumed when valid&ready
- out_tag  out  TAG_W  destination tag of the result
- out_data  out  DATA_W  result

Behaviour:
- Reset: all entries invalid; out_valid=0; out_tag=0; out_data=0; issue_ready=1 in the first cycle after reset.
- Entry state: valid, op, tag1/2, data1/2, dest. Age is tracked by a DEPTH×DEPTH age matrix.
- Issue: on valid&ready, write the lowest-index free entry. The new entry becomes younger than all live entries.
- issue_ready reflects only registered state. A slot freed by a same-cycle dispatch is not visible until the next cycle.
- Issue bypass: if issue_tagN≠0 and cdb_in_valid and cdb_in_tag==issue_tagN in the same cycle, store cdb_in_data with tag 0.
- Wakeup: every valid entry with tagN==cdb_in_tag (tag≠0, cdb_in_valid) captures cdb_in_data and clears tagN. Wakeup is registered, so the entry is ready the following cycle.
- Ready: valid && tag1==0 && tag2==0.
- Select: the oldest ready entry, and only when the output register is empty or is being consumed this cycle (!out_valid || out_ready).
- Dispatch: the selected entry is computed combinationally and loaded into out_tag/out_data with out_valid=1 at the next edge. The entry is freed at the same edge.
- Minimum latency: an op issued with both operands ready at edge E gives out_valid=1 after edge E+1.
- Output hold: out_valid, out_tag and out_data stay stable until out_ready. out_valid falls after consumption unless a new dispatch occurs at the same edge (back-to-back results are allowed).
- Ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, PASS2 (LUI/immediate move).
  - Shifts use data2[log2(DATA_W)-1:0].
  - Arithmetic wraps mod 2^DATA_W with no overflow flag.
  - Undefined op: result 0, still broadcast so the tag is released.
- Flush: at the next edge, all entries are invalidated and out_valid=0. Flush overrides a simultaneous issue, dispatch and wakeup.
- Full: issue_ready=0, and issue_valid is ignored.
- Empty: no dispatch; out_valid only drains.
- Dispatch is never blocked by out_ready alone when out_valid=0.

Optional Feature:
- Macro: ALU_STATION_PERF_EN.
- When defined: adds outputs perf_stall_cnt[31:0] and perf_disp_cnt[31:0].
  - perf_stall_cnt counts cycles with issue_valid&&!issue_ready.
  - perf_disp_cnt counts dispatches.
  - Both are cleared by rst, saturate at all-ones, and are not cleared by flush.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_defs: op-code constants, NO_LOCK=0, and the entry field layout (valid, op, tags, data, dest).
- One sub-module, alu_exec_unit: purely combinational (op, a, b) → result, shared with future ALU clones.
- The age-matrix picker stays inline.

Test Plan:
- After reset, issue ORI-style OR op=OR, d1=0x0F0, d2=0x00F, tags 0, dest=3, out_ready=1 → out_valid one cycle after acceptance, out_tag=3, out_data=0x0FF.
- Issue A (tag1=7, dest=4), then B (ready, dest=5), then drive CDB tag 7 data 10 → B is broadcast first, then A. Both ready in the same cycle → the older one is broadcast first.
- Fill 4 entries with tag1=9 → issue_ready=0 and a 5th issue is ignored. CDB tag 9 → four results on consecutive cycles with out_ready=1, oldest first.
- Hold out_ready=0 with 2 ready entries → out_valid stays 1 with stable data, and the second entry is not dispatched. Release → both drain back-to-back.
- Issue with tag2=6 while cdb_in_tag=6, data=0x55 in the same cycle → executes using 0x55 without waiting.
- SUB 0-1 → 0xFFFFFFFF; SRA 0x80000000 by 4 → 0xF8000000; SLT -1<1 → 1; SLTU → 0. Flush with a pending result → out_valid=0 and the station empty on the next cycle.
